// File: rtl/serial_adder_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding and opcodes.
package serial_adder_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_sub_cell.sv
// DIGIT-wide ripple add/sub slice; sel inverts b so that with cin=1 it subtracts.
module adder_sub_cell #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             sel,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] bx;

    always_comb begin
        bx   = b ^ {DIGIT{sel}};
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_sub.sv
// WIDTH-bit add/subtract evaluated DIGIT bits per clock, LSB first; result and flags
// are registered when the last digit is produced and held until the next completion.
module serial_adder_sub
    import serial_adder_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             digit_cmsb;
    logic [WIDTH-1:0] acc_shift;

    adder_sub_cell #(
        .DIGIT (DIGIT)
    ) u_cell (
        .a     (a_sh_q[DIGIT-1:0]),
        .b     (b_sh_q[DIGIT-1:0]),
        .sel   (sel_q),
        .cin   (carry_q),
        .sum   (digit_sum),
        .cout  (digit_cout),
        .c_msb (digit_cmsb)
    );

    // New digit enters at the MSB end so the LSB digit lands at bit 0 after STEPS shifts.
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sel_d   = sel;
                    carry_d = (sel == OP_ADD) ? 1'b0 : 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = digit_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    // Last digit: its internal top carry is the carry into the word MSB.
                    result_d = acc_shift;
                    cout_d   = digit_cout;
                    ovf_d    = digit_cout ^ digit_cmsb;
                    zero_d   = (acc_shift == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign Cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed bench for serial_adder_sub: one DIGIT=1 and one DIGIT=4 instance driven in parallel.
module tb_serial_adder_sub;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start;
    logic [1:0]      sel_v;
    logic [1:0][7:0] a_v;
    logic [1:0][7:0] b_v;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0][7:0] res;
    logic [1:0]      cout;
    logic [1:0]      ovf;
    logic [1:0]      zero;

    int vec_cnt = 0;
    int err_cnt = 0;
    int lat [2];
    int exp_lat [2];

    serial_adder_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk (clk), .rst_n (rst_n), .start (start[0]), .sel (sel_v[0]),
        .a (a_v[0]), .b (b_v[0]), .busy (busy[0]), .done (done[0]),
        .result (res[0]), .Cout (cout[0]), .ovf (ovf[0]), .zero (zero[0])
    );

    serial_adder_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk (clk), .rst_n (rst_n), .start (start[1]), .sel (sel_v[1]),
        .a (a_v[1]), .b (b_v[1]), .busy (busy[1]), .done (done[1]),
        .result (res[1]), .Cout (cout[1]), .ovf (ovf[1]), .zero (zero[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {result, Cout, ovf, zero} of instance d
    function automatic logic [10:0] obs(input int d);
        return {res[d], cout[d], ovf[d], zero[d]};
    endfunction

    function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
        logic [8:0] s;
        logic [7:0] r;
        logic       v;
        s = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + 9'(ms);
        r = s[7:0];
        if (ms) v = (ma[7] != mb[7]) && (r[7] != ma[7]);
        else    v = (ma[7] == mb[7]) && (r[7] != ma[7]);
        return {r, s[8], v, (r == 8'h00)};
    endfunction

    // Launch one operation on both instances; returns one cycle after the slower done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        logic [1:0] got;
        int cyc;
        a_v   = {ta, ta};
        b_v   = {tb, tb};
        sel_v = {ts, ts};
        start = 2'b11;
        @(posedge clk); #1;
        start  = 2'b00;
        got    = 2'b00;
        lat[0] = -1;
        lat[1] = -1;
        cyc    = 1;
        while (got != 2'b11 && cyc <= 20) begin
            for (int d = 0; d < 2; d++) begin
                if (done[d] && !got[d]) begin
                    got[d] = 1'b1;
                    lat[d] = cyc;
                end
            end
            if (got != 2'b11) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        vec_cnt++;
        if (got != 2'b11) begin
            err_cnt++;
            $display("FAIL done_timeout: got=%b required=11", got);
        end
        $display("op a=%h b=%h sel=%0d : d1 res=%h C=%0d V=%0d Z=%0d lat=%0d | d4 res=%h C=%0d V=%0d Z=%0d lat=%0d",
                 ta, tb, ts, res[0], cout[0], ovf[0], zero[0], lat[0],
                 res[1], cout[1], ovf[1], zero[1], lat[1]);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 2'b00;
        sel_v = 2'b00;
        a_v   = '0;
        b_v   = '0;
        #2;
        for (int d = 0; d < 2; d++) begin
            vec_cnt++;
            if ({busy[d], done[d], obs(d)} !== 13'h0) begin
                err_cnt++;
                $display("FAIL reset_outputs d%0d: got %h required 0", d, {busy[d], done[d], obs(d)});
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_idle busy: got %b required 00", busy);
        end
        $display("reset: busy=%b done=%b", busy, done);
    endtask

    task automatic test_add();
        logic [7:0]  ta [3] = '{8'h35, 8'hFF, 8'h7F};
        logic [7:0]  tb [3] = '{8'h4A, 8'h01, 8'h01};
        logic [10:0] ex [3] = '{{8'h7F, 3'b000}, {8'h00, 3'b101}, {8'h80, 3'b010}};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0);
            for (int d = 0; d < 2; d++) begin
                vec_cnt++;
                if (obs(d) !== ex[i]) begin
                    err_cnt++;
                    $display("FAIL add%0d d%0d res/C/V/Z: got %h required %h", i, d, obs(d), ex[i]);
                end
                if (i == 0) begin
                    vec_cnt++;
                    if (lat[d] !== exp_lat[d]) begin
                        err_cnt++;
                        $display("FAIL latency d%0d: got %0d required %0d", d, lat[d], exp_lat[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0]  ta [3] = '{8'h80, 8'h05, 8'h3C};
        logic [7:0]  tb [3] = '{8'h01, 8'h07, 8'h3C};
        logic [10:0] ex [3] = '{{8'h7F, 3'b110}, {8'hFE, 3'b000}, {8'h00, 3'b101}};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b1);
            for (int d = 0; d < 2; d++) begin
                vec_cnt++;
                if (obs(d) !== ex[i]) begin
                    err_cnt++;
                    $display("FAIL sub%0d d%0d res/C/V/Z: got %h required %h", i, d, obs(d), ex[i]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  vals [12] = '{8'h00, 8'h01, 8'h02, 8'h3C, 8'h55, 8'h7E,
                                   8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};
        logic [10:0] ex;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                for (int j = 0; j < 12; j++) begin
                    run_op(vals[i], vals[j], s[0]);
                    ex = model(vals[i], vals[j], s[0]);
                    for (int d = 0; d < 2; d++) begin
                        vec_cnt++;
                        if (obs(d) !== ex) begin
                            err_cnt++;
                            $display("FAIL sweep d%0d a=%h b=%h sel=%0d: got %h required %h",
                                     d, vals[i], vals[j], s, obs(d), ex);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ndone;
        int extra;
        logic dropped;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b1;
            a_v[d]   = 8'h11;
            b_v[d]   = 8'h22;
            sel_v[d] = 1'b0;
            @(posedge clk); #1;
            b_v[d]   = 8'h99;
            sel_v[d] = 1'b1;
            cyc      = 1;
            ndone    = 0;
            dropped  = 1'b0;
            while (ndone == 0 && cyc <= 20) begin
                if (!busy[d]) dropped = 1'b1;
                if (done[d]) ndone++;
                else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            // start is still high during the DONE cycle and must be ignored.
            @(posedge clk); #1;
            start[d] = 1'b0;
            vec_cnt++;
            if (busy[d] !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold_busy_after_done d%0d: got %b required 0", d, busy[d]);
            end
            extra = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (done[d]) extra++;
            end
            vec_cnt++;
            if ({ndone, dropped} !== {32'd1, 1'b0}) begin
                err_cnt++;
                $display("FAIL hold_single_done d%0d: dones=%0d busy_gap=%0d required 1/0", d, ndone, dropped);
            end
            vec_cnt++;
            if (obs(d) !== {8'h33, 3'b000}) begin
                err_cnt++;
                $display("FAIL hold_result d%0d: got %h required %h", d, obs(d), {8'h33, 3'b000});
            end
            vec_cnt++;
            if (extra !== 0) begin
                err_cnt++;
                $display("FAIL hold_no_restart d%0d: got %0d dones required 0", d, extra);
            end
            $display("hold d%0d: dones=%0d res=%h extra=%0d", d, ndone, res[d], extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int extra;
        a_v   = {8'h12, 8'h12};
        b_v   = {8'h34, 8'h34};
        sel_v = 2'b00;
        start = 2'b11;
        @(posedge clk); #1;
        start = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vec_cnt++;
            if ({busy[d], done[d], obs(d)} !== 13'h0) begin
                err_cnt++;
                $display("FAIL midrun_reset d%0d: got %h required 0", d, {busy[d], done[d], obs(d)});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            extra += int'(done[0]) + int'(done[1]);
        end
        vec_cnt++;
        if (extra !== 0) begin
            err_cnt++;
            $display("FAIL midrun_no_done: got %0d dones required 0", extra);
        end
        $display("midrun reset: dones after abort=%0d", extra);
        run_op(8'h12, 8'h34, 1'b0);
        for (int d = 0; d < 2; d++) begin
            vec_cnt++;
            if (obs(d) !== {8'h46, 3'b000}) begin
                err_cnt++;
                $display("FAIL post_reset_op d%0d: got %h required %h", d, obs(d), {8'h46, 3'b000});
            end
        end
    endtask

    initial begin
        exp_lat[0] = 9;
        exp_lat[1] = 3;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
